// File: rtl/merge_row_pkg.sv
// Shared definitions for the merge row and its load controller:
// state encoding, default geometry and width helpers.
package merge_row_pkg;

    // Controller states: collecting words, or presenting a full row
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Default geometry shared with the merge row itself
    localparam int WIDTH_DEF = 2;
    localparam int N_DEF     = 2;
    localparam int R_DEF     = 4;

    // Width of the slot index for r slots (at least one bit)
    function automatic int idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // Width of a slot count that can hold the value r
    function automatic int cnt_w(input int r);
        return $clog2(r + 1);
    endfunction

    localparam int IDX_W_DEF = idx_w(R_DEF);
    localparam int CNT_W_DEF = cnt_w(R_DEF);

endpackage

// File: rtl/merge_row_load_ctrl_if.sv
// Handshake bundle between the upstream source, the load controller and
// the row consumer. The flush line exists only when ROW_FLUSH_EN is defined.
interface merge_row_load_ctrl_if
    import merge_row_pkg::*;
#(
    parameter int R = R_DEF
);
    localparam int CNT_W = cnt_w(R);

    logic             in_valid;
    logic             in_ready;
    logic [R-1:0]     load;
    logic             row_valid;
    logic             row_ready;
    logic [CNT_W-1:0] row_count;
    logic             busy;
`ifdef ROW_FLUSH_EN
    logic             flush;

    // Controller side
    modport slave (
        input  in_valid, row_ready, flush,
        output in_ready, load, row_valid, row_count, busy
    );

    // Environment side (source and consumer)
    modport master (
        output in_valid, row_ready, flush,
        input  in_ready, load, row_valid, row_count, busy
    );
`else
    // Controller side
    modport slave (
        input  in_valid, row_ready,
        output in_ready, load, row_valid, row_count, busy
    );

    // Environment side (source and consumer)
    modport master (
        output in_valid, row_ready,
        input  in_ready, load, row_valid, row_count, busy
    );
`endif

endinterface

// File: rtl/merge_row_load_ctrl_dec.sv
// slot_onehot_dec: turns a slot index plus enable into a one-hot write
// enable vector; all-zero when the enable is low.
module slot_onehot_dec
    import merge_row_pkg::*;
#(
    parameter int R     = R_DEF,
    parameter int IDX_W = idx_w(R)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [R-1:0]     onehot
);

    // Compare against every slot number so out-of-range indices decode to zero
    always_comb begin
        onehot = '0;
        for (int i = 0; i < R; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/merge_row_load_ctrl.sv
// merge_row_load_ctrl: steers incoming words into consecutive row slots
// and presents the completed row to the consumer until it is taken.
// Optional feature macro: ROW_FLUSH_EN (adds the flush input, which closes
// a partially filled row early).
module merge_row_load_ctrl
    import merge_row_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int n     = N_DEF,
    parameter int R     = R_DEF
) (
    input logic                  clk,
    input logic                  rst,
    merge_row_load_ctrl_if.slave bus
);

    localparam int IDX_W = idx_w(R);
    localparam int CNT_W = cnt_w(R);

    // An illegal geometry leaves the controller inert rather than mis-steering
    localparam bit CFG_OK = (R >= 2) && (R <= 16) && (WIDTH > 0) && (n > 0);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_q;
    logic             beat;
    logic             last;
    logic             flush_req;
    logic [CNT_W-1:0] idx_ext;

`ifdef ROW_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    // in_ready is gated by reset so nothing is accepted while rst is low
    assign bus.in_ready  = rst && CFG_OK && (state == FILL);
    assign beat          = bus.in_valid && bus.in_ready;
    assign last          = (idx == IDX_W'(R - 1));
    assign idx_ext       = CNT_W'(idx);

    assign bus.row_valid = (state == HOLD);
    assign bus.row_count = cnt_q;
    assign bus.busy      = (idx != '0) || (state == HOLD);

    slot_onehot_dec #(
        .R     (R),
        .IDX_W (IDX_W)
    ) u_load_dec (
        .idx    (idx),
        .en     (beat),
        .onehot (bus.load)
    );

    // Fill/hold sequencing; cnt_q is nonzero only while the row is presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            idx   <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (beat) begin
                        if (last || flush_req) begin
                            state <= HOLD;
                            idx   <= '0;
                            cnt_q <= idx_ext + CNT_W'(1);
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (flush_req && (idx != '0)) begin
                        state <= HOLD;
                        idx   <= '0;
                        cnt_q <= idx_ext;
                    end
                end
                HOLD: begin
                    if (bus.row_ready) begin
                        state <= FILL;
                        cnt_q <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                    idx   <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_row_load_ctrl.sv
// Self-checking bench for merge_row_load_ctrl (R=4) against a slot-count
// reference model; flush scenarios are included when ROW_FLUSH_EN is defined.
module tb_merge_row_load_ctrl;

    localparam int R = 4;

    logic clk;
    logic rst;

    merge_row_load_ctrl_if #(.R(R)) ifc ();

    merge_row_load_ctrl #(
        .WIDTH (2),
        .n     (2),
        .R     (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words currently held, whether the row is presented,
    // and how many words the presented row carries.
    int filled  = 0;
    bit holding = 1'b0;
    int row_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit iv);
        logic [31:0] exp_load;
        exp_load = (iv && !holding) ? (32'd1 << filled) : 32'd0;
        check_eq("in_ready",  32'(ifc.in_ready),  32'(!holding));
        check_eq("load",      32'(ifc.load),      exp_load);
        check_eq("row_valid", 32'(ifc.row_valid), 32'(holding));
        check_eq("row_count", 32'(ifc.row_count), holding ? 32'(row_cnt) : 32'd0);
        check_eq("busy",      32'(ifc.busy),      32'(holding || (filled != 0)));
        check_eq("load_onehot", 32'($countones(ifc.load) <= 1), 32'd1);
    endtask

    // One clock cycle: drive, check before the edge, then advance the model
    task automatic step(input bit iv, input bit rr, input bit fl);
        bit fl_eff;
        @(negedge clk);
        ifc.in_valid  = iv;
        ifc.row_ready = rr;
`ifdef ROW_FLUSH_EN
        ifc.flush     = fl;
        fl_eff        = fl;
`else
        fl_eff        = 1'b0;
`endif
        #1;
        check_outputs(iv);
        @(posedge clk);
        if (holding) begin
            if (rr) begin
                holding = 1'b0;
                row_cnt = 0;
            end
        end else if (iv) begin
            filled++;
            if (filled == R || fl_eff) begin
                holding = 1'b1;
                row_cnt = filled;
                filled  = 0;
            end
        end else if (fl_eff && filled > 0) begin
            holding = 1'b1;
            row_cnt = filled;
            filled  = 0;
        end
    endtask

    // Asynchronous reset in the middle of a cycle
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_load",      32'(ifc.load),      32'd0);
        check_eq("rst_row_valid", 32'(ifc.row_valid), 32'd0);
        check_eq("rst_busy",      32'(ifc.busy),      32'd0);
        check_eq("rst_in_ready",  32'(ifc.in_ready),  32'd0);
        filled  = 0;
        holding = 1'b0;
        row_cnt = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    int last_rv;
    int rv_seen;

    initial begin
        rst           = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.row_ready = 1'b0;
`ifdef ROW_FLUSH_EN
        ifc.flush     = 1'b0;
`endif
        #3;
        check_eq("reset_in_ready",  32'(ifc.in_ready),  32'd0);
        check_eq("reset_load",      32'(ifc.load),      32'd0);
        check_eq("reset_row_valid", 32'(ifc.row_valid), 32'd0);
        check_eq("reset_row_count", 32'(ifc.row_count), 32'd0);
        check_eq("reset_busy",      32'(ifc.busy),      32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Continuous fill, then hold for 10 cycles with no consumer
        for (int i = 0; i < R + 10; i++) step(1'b1, 1'b0, 1'b0);
        // Single-cycle consumer pulse, then the next beat lands in slot 0
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Alternating in_valid
        for (int i = 0; i < 10; i++) step(i[0] == 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Reset after two beats, then refill from slot 0
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        pulse_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        pulse_reset();

`ifdef ROW_FLUSH_EN
        // Flush with no beat after two beats
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        // Flush together with the third beat
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        // Flush at slot 0 is ignored
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Flush on the last beat
        for (int i = 0; i < R; i++) step(1'b1, 1'b0, i == R - 1);
        step(1'b0, 1'b1, 1'b0);
`endif

        // Back-to-back batches with the consumer always ready
        last_rv = -1;
        rv_seen = 0;
        for (int i = 0; i < 3 * (R + 1); i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (ifc.row_valid) begin
                if (last_rv >= 0) check_eq("batch_period", 32'(i - last_rv), 32'(R + 1));
                last_rv = i;
                rv_seen++;
            end
        end
        check_eq("batches_seen", 32'(rv_seen), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0));
            if (i == 200) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
